// File: rtl/i2c_window_seq.sv
// Initiator side of the img2col ifmap window handshake: sweeps the convolution
// window grid over one tile and hands each window to the img2col unit in turn.
module i2c_window_seq #(
  parameter int ADDR_WID = 10,
  parameter int DIM_WID  = 6,
  parameter int CNT_WID  = 10
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                seq_start,
  input  logic                seq_abort,
  input  logic [2:0]          ksize,
  input  logic [1:0]          stride,
  input  logic [1:0]          pad,
  input  logic [DIM_WID-1:0]  tile_length,
  input  logic [DIM_WID-1:0]  tile_height,
  input  logic                i2c_ready,
  input  logic                i2c_done,
  output logic                i2c_ifm_start,
  output logic                addr_valid,
  output logic [ADDR_WID-1:0] base_addr,
  output logic                seq_busy,
  output logic                seq_done,
  output logic [CNT_WID-1:0]  win_cnt
);

  localparam int CW = 8;
  localparam int LW = DIM_WID + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_STEP,
    S_FINISH
  } state_t;

  state_t state;

  logic signed [CW-1:0] x, y;
  logic [2:0]           k_q;
  logic [1:0]           s_q;
  logic [1:0]           p_q;
  logic [DIM_WID-1:0]   tl_q, th_q;

  logic signed [CW-1:0] kk, sw, pw, tlw, thw, x_adv, x_nxt, y_nxt;
  logic                 x_wrap, sweep_end, win_ok, cfg_legal;
  logic [ADDR_WID-1:0]  addr_calc;
  logic [LW-1:0]        k_in, len_in, hgt_in;

  always_comb begin
    kk  = CW'(k_q);
    sw  = CW'(s_q);
    pw  = CW'(p_q);
    tlw = CW'(tl_q);
    thw = CW'(th_q);

    win_ok    = !x[CW-1] && !y[CW-1] && ((x + kk) <= tlw) && ((y + kk) <= thw);
    addr_calc = ADDR_WID'(y) * ADDR_WID'(tl_q) + ADDR_WID'(x);

    // Row wrap and end-of-sweep are both judged on the already-advanced position.
    x_adv     = x + sw;
    x_wrap    = (x_adv + kk) > (tlw + pw);
    x_nxt     = x_wrap ? -pw : x_adv;
    y_nxt     = x_wrap ? (y + sw) : y;
    sweep_end = (y_nxt + kk) > (thw + pw);

    k_in      = LW'(ksize);
    len_in    = LW'(tile_length) + LW'({pad, 1'b0});
    hgt_in    = LW'(tile_height) + LW'({pad, 1'b0});
    cfg_legal = ((ksize == 3'd1) || (ksize == 3'd3) || (ksize == 3'd5)) &&
                (k_in <= len_in) && (k_in <= hgt_in);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      k_q           <= '0;
      s_q           <= '0;
      p_q           <= '0;
      tl_q          <= '0;
      th_q          <= '0;
      i2c_ifm_start <= 1'b0;
      addr_valid    <= 1'b0;
      base_addr     <= '0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      win_cnt       <= '0;
    end else begin
      i2c_ifm_start <= 1'b0;
      seq_done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (seq_start) begin
            if (cfg_legal) begin
              k_q      <= ksize;
              s_q      <= (stride == 2'd0) ? 2'd1 : stride;
              p_q      <= pad;
              tl_q     <= tile_length;
              th_q     <= tile_height;
              x        <= -CW'(pad);
              y        <= -CW'(pad);
              win_cnt  <= '0;
              seq_busy <= 1'b1;
              state    <= S_CALC;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_CALC: begin
          addr_valid <= win_ok;
          base_addr  <= win_ok ? addr_calc : '0;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (i2c_ready) begin
            i2c_ifm_start <= 1'b1;
            win_cnt       <= win_cnt + CNT_WID'(1);
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i2c_done) state <= S_STEP;
        end
        S_STEP: begin
          if (seq_abort) begin
            state <= S_FINISH;
          end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            state <= sweep_end ? S_FINISH : S_CALC;
          end
        end
        S_FINISH: begin
          seq_done <= 1'b1;
          seq_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_window_seq.sv
// Scoreboard bench for i2c_window_seq: a window-grid reference model fills the
// expectation queue, a monitor pops one entry per i2c_ifm_start pulse.
module tb_i2c_window_seq;
  localparam int AW = 10;
  localparam int DW = 6;
  localparam int CN = 10;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          seq_start, seq_abort;
  logic [2:0]    ksize;
  logic [1:0]    stride, pad;
  logic [DW-1:0] tile_length, tile_height;
  logic          i2c_ready, i2c_done;
  logic          i2c_ifm_start, addr_valid, seq_busy, seq_done;
  logic [AW-1:0] base_addr;
  logic [CN-1:0] win_cnt;

  always #5 clock = ~clock;

  i2c_window_seq #(.ADDR_WID(AW), .DIM_WID(DW), .CNT_WID(CN)) dut (
    .clock(clock), .rst_n(rst_n), .seq_start(seq_start), .seq_abort(seq_abort),
    .ksize(ksize), .stride(stride), .pad(pad), .tile_length(tile_length),
    .tile_height(tile_height), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
    .i2c_ifm_start(i2c_ifm_start), .addr_valid(addr_valid), .base_addr(base_addr),
    .seq_busy(seq_busy), .seq_done(seq_done), .win_cnt(win_cnt)
  );

  typedef struct {
    bit v;
    int base;
  } win_t;

  win_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   starts_seen = 0;
  int   done_cnt = 0;
  int   starts_base, done_base;
  int   resp_delay = 0;   // 0 selects a random delay per window
  int   ready_mode = 2;   // 0 random, 1 forced low, 2 forced high

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate the window grid directly from the sweep rules.
  task automatic model(input int k, input int s, input int p, input int tl, input int th,
                       input int limit, output int n);
    int  se;
    bit  legal;
    win_t w;
    n = 0;
    legal = (k == 1 || k == 3 || k == 5) && (k <= tl + 2 * p) && (k <= th + 2 * p);
    if (!legal) return;
    se = (s == 0) ? 1 : s;
    for (int yy = -p; yy + k <= th + p; yy += se) begin
      for (int xx = -p; xx + k <= tl + p; xx += se) begin
        if (limit == 0 || n < limit) begin
          w.v    = (xx >= 0) && (yy >= 0) && (xx + k <= tl) && (yy + k <= th);
          w.base = w.v ? ((yy * tl + xx) % (1 << AW)) : 0;
          exp_q.push_back(w);
          n++;
        end
      end
    end
  endtask

  // Leaves the caller at the negedge after the sampling edge of seq_start.
  task automatic start_sweep(input int k, input int s, input int p, input int tl,
                             input int th, input int limit, output int n);
    exp_q.delete();
    model(k, s, p, tl, th, limit, n);
    starts_base = starts_seen;
    done_base   = done_cnt;
    @(negedge clock);
    ksize = 3'(k); stride = 2'(s); pad = 2'(p);
    tile_length = DW'(tl); tile_height = DW'(th);
    seq_start = 1'b1;
    @(negedge clock);
    seq_start = 1'b0;
    ksize = 3'($urandom_range(0, 7)); stride = 2'($urandom_range(0, 3));
    pad = 2'($urandom_range(0, 3));
    tile_length = DW'($urandom_range(0, 63)); tile_height = DW'($urandom_range(0, 63));
    chk("busy_after_start", seq_busy, (n > 0) ? 1 : 0);
  endtask

  task automatic wait_starts(input int n);
    int cyc = 0;
    while (starts_seen - starts_base < n && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 5000) chk("start_timeout", starts_seen - starts_base, n);
  endtask

  task automatic wait_done(input int n_exp, input bit chk_cnt);
    int cyc = 0;
    while (seq_done !== 1'b1 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 20000) chk("sweep_timeout", 0, 1);
    if (n_exp == 0) chk("empty_done_latency", cyc, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (chk_cnt) chk("win_cnt", win_cnt, n_exp);
    repeat (3) @(negedge clock);
    chk("single_seq_done", done_cnt - done_base, 1);
    chk("busy_clear", seq_busy, 0);
    exp_q.delete();
  endtask

  // Monitor: one expectation per start pulse, plus seq_done counting.
  initial begin
    win_t w;
    bit   prev_start = 1'b0;
    forever begin
      @(negedge clock);
      if (seq_done === 1'b1) done_cnt++;
      if (i2c_ifm_start === 1'b1) begin
        starts_seen++;
        if (prev_start) chk("start_one_cycle", 1, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("addr_valid", addr_valid, w.v);
          chk("base_addr", base_addr, w.base);
        end
      end
      prev_start = (i2c_ifm_start === 1'b1);
    end
  end

  // img2col responder: one done pulse per start after a delay.
  initial begin
    int d;
    i2c_done = 1'b0;
    forever begin
      @(negedge clock);
      if (i2c_ifm_start === 1'b1) begin
        d = (resp_delay != 0) ? resp_delay : int'($urandom_range(1, 6));
        repeat (d - 1) @(negedge clock);
        i2c_done = 1'b1;
        @(negedge clock);
        i2c_done = 1'b0;
      end
    end
  end

  initial begin
    i2c_ready = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      case (ready_mode)
        0:       i2c_ready = ($urandom_range(0, 3) != 0);
        1:       i2c_ready = 1'b0;
        default: i2c_ready = 1'b1;
      endcase
    end
  end

  initial begin
    int n, b0, k, s, p, tl, th, ab;
    bit ok;
    int ktab[5];
    ktab = '{1, 3, 5, 4, 0};
    rst_n = 1'b0; seq_start = 1'b0; seq_abort = 1'b0;
    ksize = '0; stride = '0; pad = '0; tile_length = '0; tile_height = '0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("reset_outputs", {i2c_ifm_start, addr_valid, seq_busy, seq_done}, 0);
    chk("reset_base", base_addr, 0);
    chk("reset_cnt", win_cnt, 0);

    // 4x4 k3 s1 p0 with 12-cycle responder; checks start latency.
    ready_mode = 2; resp_delay = 12;
    start_sweep(3, 1, 0, 4, 4, 0, n);
    @(negedge clock);
    chk("latency_edge1", i2c_ifm_start, 0);
    @(negedge clock);
    chk("latency_edge2", i2c_ifm_start, 1);
    wait_done(n, 1);

    // Padding: 16 windows, plus an ignored mid-sweep seq_start.
    resp_delay = 0; ready_mode = 0;
    start_sweep(3, 1, 1, 4, 4, 0, n);
    wait_starts(5);
    @(negedge clock);
    ksize = 3'd1; tile_length = 6'd2; tile_height = 6'd2; seq_start = 1'b1;
    @(negedge clock);
    seq_start = 1'b0;
    wait_done(n, 1);

    start_sweep(3, 2, 0, 5, 5, 0, n);
    wait_done(n, 1);
    start_sweep(1, 0, 0, 2, 2, 0, n);
    wait_done(n, 1);

    // Empty sweeps: oversize and illegal kernels.
    start_sweep(5, 1, 0, 3, 3, 0, n);
    wait_done(n, 0);
    start_sweep(4, 1, 0, 3, 3, 0, n);
    wait_done(n, 0);

    // Ready withheld in ISSUE.
    ready_mode = 1;
    repeat (2) @(negedge clock);
    start_sweep(3, 1, 0, 4, 4, 0, n);
    repeat (2) @(negedge clock);
    b0 = int'(base_addr);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (i2c_ifm_start !== 1'b0 || int'(base_addr) != b0) ok = 1'b0;
    end
    chk("hold_no_start_stable", ok, 1);
    chk("hold_base", b0, 0);
    ready_mode = 2;
    @(negedge clock);
    chk("start_after_ready", i2c_ifm_start, 1);
    wait_done(n, 1);

    // Abort during window 2, and abort coinciding with the last window.
    resp_delay = 8;
    start_sweep(3, 1, 0, 4, 4, 2, n);
    wait_starts(2);
    seq_abort = 1'b1;
    wait_done(n, 1);
    seq_abort = 1'b0;
    start_sweep(3, 2, 0, 5, 5, 0, n);
    wait_starts(n);
    seq_abort = 1'b1;
    wait_done(n, 1);
    seq_abort = 1'b0;

    // Reset while in WAIT.
    resp_delay = 30;
    start_sweep(3, 1, 0, 4, 4, 0, n);
    wait_starts(1);
    repeat (3) @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {i2c_ifm_start, addr_valid, seq_busy, seq_done}, 0);
    chk("async_reset_base", base_addr, 0);
    chk("async_reset_cnt", win_cnt, 0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_done_after_reset", done_cnt - done_base, 0);
    exp_q.delete();

    // Randomized sweeps.
    resp_delay = 0; ready_mode = 0;
    for (int i = 0; i < 20; i++) begin
      k  = ktab[$urandom_range(0, 4)];
      s  = int'($urandom_range(0, 3));
      p  = int'($urandom_range(0, 3));
      tl = int'($urandom_range(1, 7));
      th = int'($urandom_range(1, 7));
      ab = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (ab == 1) resp_delay = 8;
      start_sweep(k, s, p, tl, th, ab, n);
      if (ab == 1 && n > 0) begin
        wait_starts(1);
        seq_abort = 1'b1;
      end
      wait_done(n, n > 0);
      seq_abort = 1'b0;
      resp_delay = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
